// File: rtl/exu_stage.sv
// exu_stage: RV32 execute stage (operand select, ALU, result mux, EXU/MEM register); EXU_MUL_EN enables MUL/MULHU on opcodes 14/15
module exu_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] pc,
  input  logic [3:0]      csr_wen,
  input  logic            R_wen,
  input  logic            mem_wen,
  input  logic            mem_ren,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] imm,
  input  logic [1:0]      imm_opcode,
  input  logic [3:0]      alu_opcode,
  input  logic            inv_flag,
  input  logic            jump_flag,
  input  logic [1:0]      add1_choice,
  input  logic [1:0]      add2_choice,
  input  logic [XLEN-1:0] rs1_value,
  input  logic [XLEN-1:0] rs2_value,
  input  logic [XLEN-1:0] csrs,
  output logic            jump_flag_next,
  output logic [2:0]      funct3_next,
  output logic [XLEN-1:0] rs2_value_next,
  output logic [4:0]      rd_next,
  output logic [XLEN-1:0] csrs_next,
  output logic [3:0]      csr_wen_next,
  output logic            R_wen_next,
  output logic            mem_wen_next,
  output logic            mem_ren_next,
  output logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] EX_result
);
  logic [XLEN-1:0] a, b, alu, res;
`ifdef EXU_MUL_EN
  logic [2*XLEN-1:0] prod;
  assign prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
`endif
  always_comb begin
    a = add1_choice == 2'd0 ? rs1_value : add1_choice == 2'd1 ? pc : add1_choice == 2'd2 ? '0 : csrs;
    b = add2_choice == 2'd0 ? rs2_value : add2_choice == 2'd1 ? imm : add2_choice == 2'd2 ? XLEN'(4) : csrs;
    case (alu_opcode)
      4'd0:    alu = a + b;
      4'd1:    alu = a - b;
      4'd2:    alu = a << b[4:0];
      4'd3:    alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd4:    alu = {{(XLEN-1){1'b0}}, a < b};
      4'd5:    alu = a ^ b;
      4'd6:    alu = a >> b[4:0];
      4'd7:    alu = $signed(a) >>> b[4:0];
      4'd8:    alu = a | b;
      4'd9:    alu = a & b;
      4'd10:   alu = a;
      4'd11:   alu = b;
      4'd12:   alu = a & ~b;
      4'd13:   alu = {{(XLEN-1){1'b0}}, a == b};
`ifdef EXU_MUL_EN
      4'd14:   alu = prod[XLEN-1:0];
      4'd15:   alu = prod[2*XLEN-1:XLEN];
`endif
      default: alu = '0;
    endcase
    alu[0] = alu[0] ^ inv_flag;
    res = imm_opcode == 2'd0 ? alu : imm_opcode == 2'd1 ? pc + XLEN'(4) : imm_opcode == 2'd2 ? imm : pc + imm;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_flag_next <= 1'b0;
      funct3_next    <= '0;
      rs2_value_next <= '0;
      rd_next        <= '0;
      csrs_next      <= '0;
      csr_wen_next   <= '0;
      R_wen_next     <= 1'b0;
      mem_wen_next   <= 1'b0;
      mem_ren_next   <= 1'b0;
      pc_next        <= '0;
      EX_result      <= '0;
    end else begin
      jump_flag_next <= jump_flag;
      funct3_next    <= funct3;
      rs2_value_next <= rs2_value;
      rd_next        <= rd;
      csrs_next      <= csrs;
      csr_wen_next   <= csr_wen;
      R_wen_next     <= R_wen;
      mem_wen_next   <= mem_wen;
      mem_ren_next   <= mem_ren;
      pc_next        <= pc;
      EX_result      <= res;
    end
  end
endmodule

// File: tb/tb_exu_stage.sv
// tb_exu_stage: directed and random checks of exu_stage against a behavioural model
module tb_exu_stage;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [2:0] funct3;
  logic [31:0] pc, imm, rs1_value, rs2_value, csrs;
  logic [3:0] csr_wen, alu_opcode;
  logic R_wen, mem_wen, mem_ren, inv_flag, jump_flag;
  logic [4:0] rd;
  logic [1:0] imm_opcode, add1_choice, add2_choice;
  logic jump_flag_next, R_wen_next, mem_wen_next, mem_ren_next;
  logic [2:0] funct3_next;
  logic [31:0] rs2_value_next, csrs_next, pc_next, EX_result;
  logic [4:0] rd_next;
  logic [3:0] csr_wen_next;
  logic e_jf = 0, e_rw = 0, e_mw = 0, e_mr = 0;
  logic [2:0] e_f3 = 0;
  logic [31:0] e_rs2 = 0, e_csrs = 0, e_pc = 0, e_res = 0;
  logic [4:0] e_rd = 0;
  logic [3:0] e_cw = 0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  exu_stage dut (
    .clk(clk), .rst_n(rst_n), .funct3(funct3), .pc(pc), .csr_wen(csr_wen), .R_wen(R_wen),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .rd(rd), .imm(imm), .imm_opcode(imm_opcode),
    .alu_opcode(alu_opcode), .inv_flag(inv_flag), .jump_flag(jump_flag),
    .add1_choice(add1_choice), .add2_choice(add2_choice), .rs1_value(rs1_value),
    .rs2_value(rs2_value), .csrs(csrs), .jump_flag_next(jump_flag_next),
    .funct3_next(funct3_next), .rs2_value_next(rs2_value_next), .rd_next(rd_next),
    .csrs_next(csrs_next), .csr_wen_next(csr_wen_next), .R_wen_next(R_wen_next),
    .mem_wen_next(mem_wen_next), .mem_ren_next(mem_ren_next), .pc_next(pc_next),
    .EX_result(EX_result)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result computed from the instruction-level meaning of each opcode.
  function automatic logic [31:0] model_result();
    logic [31:0] asel [4];
    logic [31:0] bsel [4];
    logic [31:0] a, b, r;
    logic [63:0] p, sx;
    int sh;
    asel = '{rs1_value, pc, 32'd0, csrs};
    bsel = '{rs2_value, imm, 32'd4, csrs};
    a = asel[add1_choice];
    b = bsel[add2_choice];
    sh = int'(b % 32);
    p = 64'(a) * 64'(b);
    sx = {{32{a[31]}}, a} >> sh;
    case (alu_opcode)
      0: r = a + b;
      1: r = a + ~b + 1;
      2: r = 32'(64'(a) * (64'd1 << sh));
      3: r = 32'((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
      4: r = 32'(a < b);
      5: r = a ^ b;
      6: r = 32'(64'(a) >> sh);
      7: r = sx[31:0];
      8: r = a | b;
      9: r = a & b;
      10: r = a;
      11: r = b;
      12: r = a & ~b;
      13: r = 32'(a == b);
`ifdef EXU_MUL_EN
      14: r = p[31:0];
      15: r = p[63:32];
`endif
      default: r = 0;
    endcase
    if (inv_flag) r[0] = ~r[0];
    case (imm_opcode)
      0: return r;
      1: return pc + 4;
      2: return imm;
      default: return pc + imm;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {e_jf, e_rw, e_mw, e_mr, e_f3, e_rd, e_cw} <= '0;
      {e_rs2, e_csrs, e_pc, e_res} <= '0;
    end else begin
      e_jf <= jump_flag; e_rw <= R_wen; e_mw <= mem_wen; e_mr <= mem_ren;
      e_f3 <= funct3; e_rd <= rd; e_cw <= csr_wen;
      e_rs2 <= rs2_value; e_csrs <= csrs; e_pc <= pc; e_res <= model_result();
    end
  end

  always @(negedge clk) begin
    chk("res", EX_result, e_res);
    chk("pc", pc_next, e_pc);
    chk("rs2", rs2_value_next, e_rs2);
    chk("csrs", csrs_next, e_csrs);
    chk("rd", 32'(rd_next), 32'(e_rd));
    chk("funct3", 32'(funct3_next), 32'(e_f3));
    chk("csr_wen", 32'(csr_wen_next), 32'(e_cw));
    chk("jump", 32'(jump_flag_next), 32'(e_jf));
    chk("R_wen", 32'(R_wen_next), 32'(e_rw));
    chk("mem_wen", 32'(mem_wen_next), 32'(e_mw));
    chk("mem_ren", 32'(mem_ren_next), 32'(e_mr));
  end

  task automatic rnd_pass();
    funct3 = 3'($urandom); csr_wen = 4'($urandom); R_wen = 1'($urandom);
    mem_wen = 1'($urandom); mem_ren = 1'($urandom); rd = 5'($urandom); jump_flag = 1'($urandom);
  endtask

  task automatic rnd_all();
    rnd_pass();
    pc = $urandom; imm = $urandom; rs1_value = $urandom; rs2_value = $urandom; csrs = $urandom;
    imm_opcode = 2'($urandom); alu_opcode = 4'($urandom); inv_flag = 1'($urandom);
    add1_choice = 2'($urandom); add2_choice = 2'($urandom);
    if ($urandom_range(0, 3) == 0) rs2_value = rs1_value;
  endtask

  task automatic ins(input logic [1:0] a1, input logic [1:0] a2, input logic [3:0] op,
                     input logic inv, input logic [1:0] io, input logic [31:0] exp, input string nm);
    @(negedge clk);
    add1_choice = a1; add2_choice = a2; alu_opcode = op; inv_flag = inv; imm_opcode = io;
    rnd_pass();
    @(posedge clk);
    #1 chk(nm, EX_result, exp);
  endtask

  initial begin
    rnd_all();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rnd_all();
      #2 chk("rst_mid_res", EX_result, 0);
      chk("rst_mid_pc", pc_next, 0);
      @(posedge clk);
      #1 chk("rst_edge_res", EX_result, 0);
      chk("rst_edge_rd", 32'(rd_next), 0);
    end
    @(negedge clk);
    rst_n = 1'b1; pc = 32'h8000_0000; rd = 5'd5; R_wen = 1'b1;
    @(posedge clk);
    #1 chk("rel_pc", pc_next, 32'h8000_0000);
    chk("rel_rd", 32'(rd_next), 5);
    chk("rel_rwen", 32'(R_wen_next), 1);
    rs1_value = 32'hFFFF_FFFF; imm = 1;
    ins(0, 1, 0, 0, 0, 32'h0, "add_wrap");
    rs1_value = 0; rs2_value = 1;
    ins(0, 0, 1, 0, 0, 32'hFFFF_FFFF, "sub_wrap");
    rs1_value = 32'hFFFF_FFFE;
    ins(0, 0, 3, 0, 0, 1, "slt");
    ins(0, 0, 4, 0, 0, 0, "sltu");
    ins(0, 0, 3, 1, 0, 0, "slt_inv");
    rs1_value = 7; rs2_value = 7;
    ins(0, 0, 13, 0, 0, 1, "eq");
    ins(0, 0, 13, 1, 0, 0, "eq_inv");
    rs1_value = 32'h8000_0000; imm = 32'h24;
    ins(0, 1, 7, 0, 0, 32'hF800_0000, "sra");
    ins(0, 1, 6, 0, 0, 32'h0800_0000, "srl");
    rs1_value = 1;
    ins(0, 1, 2, 0, 0, 32'h10, "sll");
    pc = 32'h8000_0010; imm = 32'hFFFF_FFF0;
    ins(0, 0, 0, 0, 1, 32'h8000_0014, "pc_plus4");
    ins(0, 0, 0, 0, 2, 32'hFFFF_FFF0, "imm");
    ins(0, 0, 0, 0, 3, 32'h8000_0000, "pc_imm");
    ins(1, 2, 10, 0, 0, 32'h8000_0010, "pass_a");
    ins(2, 2, 11, 1, 0, 32'h5, "pass_b_inv");
    csrs = 32'hF0; rs2_value = 32'h0F;
    ins(3, 0, 8, 0, 0, 32'hFF, "csr_or");
    chk("csrs_next", csrs_next, 32'hF0);
    rs1_value = 32'hF0F0_1234; rs2_value = 32'hFF00_FF00;
    ins(0, 0, 5, 0, 0, 32'h0FF0_ED34, "xor");
    ins(0, 0, 9, 0, 0, 32'hF000_1200, "and");
    ins(0, 0, 12, 0, 0, 32'h00F0_0034, "andn");
    rs1_value = 32'h0001_0003; rs2_value = 32'h0002_0000;
`ifdef EXU_MUL_EN
    ins(0, 0, 14, 0, 0, 32'h0006_0000, "mul");
    ins(0, 0, 15, 1, 0, 32'h3, "mulhu_inv");
`else
    ins(0, 0, 14, 0, 0, 32'h0, "op14");
    ins(0, 0, 15, 1, 0, 32'h1, "op15_inv");
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      add1_choice = 0; add2_choice = 0; alu_opcode = 0; inv_flag = 0; imm_opcode = 0;
      rs1_value = 32'(i * 100); rs2_value = 32'(i + 1);
      mem_wen = (i == 0); mem_ren = (i == 1); funct3 = 3'(i + 2);
      @(posedge clk);
      #1 chk("b2b_res", EX_result, 32'(i * 101 + 1));
      chk("b2b_rs2", rs2_value_next, 32'(i + 1));
      chk("b2b_mwen", 32'(mem_wen_next), 32'(i == 0));
      chk("b2b_mren", 32'(mem_ren_next), 32'(i == 1));
      chk("b2b_f3", 32'(funct3_next), 32'(i + 2));
    end
    repeat (300) begin
      @(negedge clk);
      rnd_all();
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("midrst_res", EX_result, 0);
    chk("midrst_pc", pc_next, 0);
    chk("midrst_rs2", rs2_value_next, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      rnd_all();
    end
    @(negedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
